led_pattern_gen: RTL

Parametrised animation source for the LED matrix frame buffer: produces an `ROWS*COLS`-bit frame and a 3-bit brightness level for the LED display driver's `leds` and `leds_pwm` inputs. It replaces the fixed free-running counter top with four selectable patterns: counter, walking, bounce and LFSR. Rate is programmable, and the block supports pause/single-step and seed loading. It sits between user controls (buttons/mode straps) and the display core.

---
 rtl/led_pattern_gen_if.sv | 25 ++
 rtl/led_pattern_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the user-control side and led_pattern_gen.
// The master drives the animation controls; the slave returns frame, update and brightness.
interface led_pattern_gen_if #(
  parameter int N = 32
);
  logic [1:0]   mode;
  logic [3:0]   rate;
  logic         pause;
  logic         step;
  logic         seed_load;
  logic [N-1:0] seed;
  logic [N-1:0] frame;
  logic         update;
  logic [2:0]   pwm_level;

  modport master (
    output mode, rate, pause, step, seed_load, seed,
    input  frame, update, pwm_level
  );

  modport slave (
    input  mode, rate, pause, step, seed_load, seed,
    output frame, update, pwm_level
  );
endinterface

// File: rtl/led_pattern_gen.sv
// LED matrix animation source: counter, walking, bounce and LFSR patterns with
// programmable rate, pause/single-step and seeding. Define LED_PATTERN_FADE_EN for triangle brightness fade.
module led_pattern_gen #(
  parameter int                   ROWS      = 8,
  parameter int                   COLS      = 4,
  parameter int                   DIV_BASE  = 1200000,
  parameter logic [ROWS*COLS-1:0] LFSR_TAPS = 32'h80200003,
  parameter logic [ROWS*COLS-1:0] LFSR_INIT = 32'h00000001
) (
  input  logic              clk12MHz,
  input  logic              reset,
  led_pattern_gen_if.slave  bus
);
  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N);
  localparam int BW = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [BW-1:0] base_cnt_reg;
  logic [3:0]    rate_cnt_reg;
  logic          step_q_reg;
  logic [1:0]    mode_q;
  logic [N-1:0]  frame_reg;
  logic [PW-1:0] pos_reg;
  logic          dir_down_reg;
  logic          update_reg;

  logic          base_tick;
  logic          tick;
  logic          step_edge;
  logic          advance;
  logic          mode_change;
  logic [PW:0]   seed_pos_wide;
  logic [PW-1:0] seed_pos;
  logic [PW-1:0] pos_next;
  logic          dir_next;
  logic [N-1:0]  lfsr_next;

  always_comb begin
    base_tick   = (base_cnt_reg == BW'(DIV_BASE - 1));
    tick        = base_tick && (rate_cnt_reg >= bus.rate);
    step_edge   = bus.step && !step_q_reg;
    advance     = bus.pause ? step_edge : tick;
    mode_change = (bus.mode != mode_q);

    // Seeded bounce position is clamped so non-power-of-two matrices stay in range
    seed_pos_wide = {1'b0, bus.seed[PW-1:0]};
    seed_pos      = (seed_pos_wide > (PW+1)'(N - 1)) ? PW'(N - 1) : bus.seed[PW-1:0];

    pos_next = dir_down_reg ? (pos_reg - PW'(1)) : (pos_reg + PW'(1));
    if (pos_next == PW'(N - 1))
      dir_next = 1'b1;
    else if (pos_next == '0)
      dir_next = 1'b0;
    else
      dir_next = dir_down_reg;

    lfsr_next = {frame_reg[N-2:0], 1'b0} ^ (frame_reg[N-1] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      base_cnt_reg <= '0;
      rate_cnt_reg <= '0;
      step_q_reg   <= 1'b0;
      mode_q       <= 2'd0;
      frame_reg    <= '0;
      pos_reg      <= '0;
      dir_down_reg <= 1'b0;
      update_reg   <= 1'b0;
    end else begin
      step_q_reg <= bus.step;
      update_reg <= 1'b0;

      // Prescaler runs regardless of mode changes; pause freezes both stages
      if (!bus.pause) begin
        if (base_tick) begin
          base_cnt_reg <= '0;
          rate_cnt_reg <= tick ? 4'd0 : (rate_cnt_reg + 4'd1);
        end else begin
          base_cnt_reg <= base_cnt_reg + BW'(1);
        end
      end

      if (bus.seed_load) begin
        update_reg <= 1'b1;
        case (mode_q)
          2'd0, 2'd1: frame_reg <= bus.seed;
          2'd2: begin
            pos_reg      <= seed_pos;
            dir_down_reg <= (seed_pos == PW'(N - 1));
            frame_reg    <= ONE << seed_pos;
          end
          default: frame_reg <= (bus.seed == '0) ? LFSR_INIT : bus.seed;
        endcase
      end else if (mode_change) begin
        mode_q     <= bus.mode;
        update_reg <= 1'b1;
        case (bus.mode)
          2'd0: frame_reg <= '0;
          2'd1: frame_reg <= ONE;
          2'd2: begin
            pos_reg      <= '0;
            dir_down_reg <= 1'b0;
            frame_reg    <= ONE;
          end
          default: frame_reg <= LFSR_INIT;
        endcase
      end else if (advance) begin
        update_reg <= 1'b1;
        case (mode_q)
          2'd0: frame_reg <= frame_reg + ONE;
          2'd1: frame_reg <= {frame_reg[N-2:0], frame_reg[N-1]};
          2'd2: begin
            pos_reg      <= pos_next;
            dir_down_reg <= dir_next;
            frame_reg    <= ONE << pos_next;
          end
          default: frame_reg <= lfsr_next;
        endcase
      end
    end
  end

  assign bus.frame  = frame_reg;
  assign bus.update = update_reg;

`ifdef LED_PATTERN_FADE_EN
  logic       advance_taken;
  logic [2:0] pwm_reg;
  logic       pwm_up_reg;

  // Only advances that actually win arbitration move the brightness
  assign advance_taken = advance && !bus.seed_load && !mode_change;

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      pwm_reg    <= 3'd7;
      pwm_up_reg <= 1'b0;
    end else if (advance_taken) begin
      if (pwm_up_reg) begin
        pwm_reg <= pwm_reg + 3'd1;
        if (pwm_reg == 3'd6)
          pwm_up_reg <= 1'b0;
      end else begin
        pwm_reg <= pwm_reg - 3'd1;
        if (pwm_reg == 3'd1)
          pwm_up_reg <= 1'b1;
      end
    end
  end

  assign bus.pwm_level = pwm_reg;
`else
  assign bus.pwm_level = 3'd7;
`endif

endmodule
